// File: rtl/demux1_8_collect_if.sv
// Bus bundle for the 1:8 collecting demultiplexer.
// The master side presents serial bits with their destination index;
// the slave side (the collector) returns the live slots, the fill mask
// and the reassembled word with its strobes.
interface demux1_8_collect_if #(
  parameter int SEL_W = 3
);
  localparam int N = 1 << SEL_W;

  logic             din;
  logic             din_valid;
  logic [SEL_W-1:0] sel;
  logic             clr;
  logic [N-1:0]     slots;
  logic [N-1:0]     filled;
  logic [N-1:0]     dout;
  logic             dout_valid;
  logic             dup_err;
  logic             busy;

  modport master (
    output din, din_valid, sel, clr,
    input  slots, filled, dout, dout_valid, dup_err, busy
  );

  modport slave (
    input  din, din_valid, sel, clr,
    output slots, filled, dout, dout_valid, dup_err, busy
  );
endinterface

// File: rtl/demux1_8_collect.sv
// 1:8 registered demultiplexer that steers each serial bit into the
// position named by its select, and publishes the rebuilt word with a
// one-cycle strobe once every position of the frame has been written.
module demux1_8_collect #(
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  demux1_8_collect_if.slave  bus
);
  localparam int N = 1 << SEL_W;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state_q;
  logic [N-1:0]   slots_q;
  logic [N-1:0]   filled_q;
  logic [N-1:0]   dout_q;
  logic           dout_valid_q;
  logic           dup_err_q;

  logic           write;
  logic [N-1:0]   onehot;
  logic [N-1:0]   slots_d;
  logic [N-1:0]   filled_d;
  logic           dup;
  logic           complete;

  // Decode the incoming write: clr wins over data, and completion is
  // judged on the mask as it would look including this write.
  always_comb begin
    write    = bus.din_valid & ~bus.clr;
    onehot   = N'(1) << bus.sel;
    slots_d  = slots_q;
    if (write) begin
      slots_d[bus.sel] = bus.din;
    end
    filled_d = filled_q | onehot;
    dup      = write & filled_q[bus.sel];
    complete = write & (&filled_d);
  end

  // Frame state machine with registered slots, mask, word and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slots_q      <= '0;
      filled_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dup_err_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      dup_err_q    <= 1'b0;
      if (bus.clr) begin
        filled_q <= '0;
        state_q  <= IDLE;
      end else if (bus.din_valid) begin
        slots_q   <= slots_d;
        dup_err_q <= dup;
        if (complete) begin
          dout_q       <= slots_d;
          dout_valid_q <= 1'b1;
          filled_q     <= '0;
          state_q      <= IDLE;
        end else begin
          filled_q <= filled_d;
          state_q  <= COLLECT;
        end
      end
    end
  end

  assign bus.slots      = slots_q;
  assign bus.filled     = filled_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dup_err    = dup_err_q;
  assign bus.busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_demux1_8_collect.sv
// Self-checking bench for demux1_8_collect: a word-level reference model
// predicts strobes into scoreboard queues, and a negedge monitor checks
// every strobe plus the live slots/mask/word against the model.
module tb_demux1_8_collect;
  localparam int SEL_W = 3;
  localparam int N     = 8;

  typedef struct {
    int          cyc;
    logic [N-1:0] word;
  } doutExp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  doutExp_t     doutQ[$];
  int           dupQ[$];
  bit           written[N];
  logic [N-1:0] mSlots = '0;
  logic [N-1:0] mDout  = '0;
  int           ord[N];

  demux1_8_collect_if #(.SEL_W(SEL_W)) bus();

  demux1_8_collect #(.SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and cycle counter used to time the strobes.
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] expMask();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = written[i];
    return m;
  endfunction

  // One cycle of stimulus: predict the outcome from the word-level model,
  // drive the bus across one clock edge, then commit the model.
  task automatic applyStimulus(bit v, bit d, int s, bit c);
    bit           nw[N];
    logic [N-1:0] ns;
    bit           all;
    bit           done;
    nw   = written;
    ns   = mSlots;
    done = 0;
    if (c) begin
      foreach (nw[i]) nw[i] = 0;
    end else if (v) begin
      ns[s] = d;
      if (written[s]) dupQ.push_back(cycle + 1);
      nw[s] = 1;
      all = 1;
      foreach (nw[i]) if (!nw[i]) all = 0;
      if (all) begin
        doutQ.push_back('{cycle + 1, ns});
        foreach (nw[i]) nw[i] = 0;
        done = 1;
      end
    end
    bus.din       = d;
    bus.sel       = s[SEL_W-1:0];
    bus.din_valid = v;
    bus.clr       = c;
    @(posedge clk);
    #1;
    written       = nw;
    mSlots        = ns;
    if (done) mDout = ns;
    bus.din_valid = 1'b0;
    bus.clr       = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(0, 0, 0, 0);
  endtask

  // mode 0 ascending, 1 descending, 2 shuffled
  task automatic makeOrder(int mode);
    for (int i = 0; i < N; i++) ord[i] = (mode == 1) ? (N - 1 - i) : i;
    if (mode == 2) begin
      for (int i = N - 1; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    end
  endtask

  task automatic sweep(logic [N-1:0] word, int mode, int maxGap);
    makeOrder(mode);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1, word[ord[i]], ord[i], 0);
      if (maxGap > 0 && i < N - 1) idle($urandom_range(0, maxGap));
    end
  endtask

  task automatic checkOutput(string tag, logic [N-1:0] expDout);
    checkVal({tag, "_filled"}, 32'(bus.filled), 32'd0);
    checkVal({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkVal({tag, "_dout"}, 32'(bus.dout), 32'(expDout));
  endtask

  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst_slots", 32'(bus.slots), 32'd0);
    checkVal("arst_filled", 32'(bus.filled), 32'd0);
    checkVal("arst_dout", 32'(bus.dout), 32'd0);
    checkVal("arst_dout_valid", 32'(bus.dout_valid), 32'd0);
    checkVal("arst_dup_err", 32'(bus.dup_err), 32'd0);
    checkVal("arst_busy", 32'(bus.busy), 32'd0);
    foreach (written[i]) written[i] = 0;
    mSlots = '0;
    mDout  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pop scoreboard entries on each strobe and track live state.
  always @(negedge clk) begin
    checkVal("mon_filled", 32'(bus.filled), 32'(expMask()));
    checkVal("mon_busy", 32'(bus.busy), 32'(expMask() != '0));
    checkVal("mon_slots", 32'(bus.slots), 32'(mSlots));
    checkVal("mon_dout", 32'(bus.dout), 32'(mDout));
    if (bus.dout_valid === 1'b1) begin
      if (doutQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_dout_valid: got 1 at cycle %0d expected 0", cycle);
      end else begin
        doutExp_t e;
        e = doutQ.pop_front();
        checkVal("dout_valid_cycle", 32'(cycle), 32'(e.cyc));
        checkVal("dout_word", 32'(bus.dout), 32'(e.word));
      end
    end else if (bus.dout_valid !== 1'b0) begin
      checkVal("dout_valid_known", 32'(bus.dout_valid), 32'd0);
    end
    if (bus.dup_err === 1'b1) begin
      if (dupQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_dup_err: got 1 at cycle %0d expected 0", cycle);
      end else begin
        checkVal("dup_err_cycle", 32'(cycle), 32'(dupQ.pop_front()));
      end
    end else if (bus.dup_err !== 1'b0) begin
      checkVal("dup_err_known", 32'(bus.dup_err), 32'd0);
    end
  end

  // Directed scenarios followed by randomized frames.
  initial begin
    logic [N-1:0] w;
    rst_n         = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sel       = '0;
    bus.clr       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_dout_valid", 32'(bus.dout_valid), 32'd0);
    checkOutput("reset", 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sweep(8'hAA, 0, 0);
    sweep(8'hF0, 0, 0);
    idle(2);
    checkOutput("b2b", 8'hF0);

    sweep(8'h5A, 1, 0);
    idle(1);
    checkOutput("reverse", 8'h5A);
    sweep(8'h5A, 2, 3);
    idle(1);
    checkOutput("shuffled_gaps", 8'h5A);

    w = 8'b1100_0101;
    for (int i = 0; i < 4; i++) applyStimulus(1, w[i], i, 0);
    applyStimulus(1, ~w[2], 2, 0);
    for (int i = 4; i < N; i++) applyStimulus(1, w[i], i, 0);
    idle(1);
    w[2] = ~w[2];
    checkOutput("dup", w);

    for (int i = 0; i < 5; i++) applyStimulus(1, 1'b1, i, 0);
    applyStimulus(1, 1'b1, 5, 1);
    checkOutput("clr", w);
    idle(2);
    sweep(8'hAA, 0, 0);
    idle(1);
    checkOutput("after_clr", 8'hAA);

    for (int i = 0; i < 5; i++) applyStimulus(1, 1'b1, i, 0);
    asyncReset();
    sweep(8'hF0, 0, 0);
    idle(1);
    checkOutput("after_arst", 8'hF0);

    for (int f = 0; f < 30; f++) begin
      w = N'($urandom);
      makeOrder(2);
      for (int i = 0; i < N; i++) begin
        if (i > 0 && $urandom_range(0, 5) == 0)
          applyStimulus(1, 1'($urandom), ord[$urandom_range(0, i - 1)], 0);
        if (i == 4 && $urandom_range(0, 9) == 0)
          applyStimulus(1, 1'($urandom), ord[i], 1);
        applyStimulus(1, w[ord[i]], ord[i], 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end

    idle(3);
    checkVal("pending_dout_valid", 32'(doutQ.size()), 32'd0);
    checkVal("pending_dup_err", 32'(dupQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1_8_collect.md
Name: demux1_8_collect

Overview:
1:8 registered demultiplexer. It is the receive-side counterpart of the 8:1 selector built from 2:1 muxes: each serial bit presented with its 3-bit select is steered into that bit position of an 8-bit word. Once all 8 positions have been written, the block publishes the reassembled byte with a one-cycle valid strobe. It sits downstream of any sel-swept 8:1 mux serializer and rebuilds the original parallel word.

Parameters:
SEL_W, 3, select width; the output word width is N = 2**SEL_W (8 at default). All values below assume the default.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active low
din  input  1  serial data bit
din_valid  input  1  din/sel qualify on this cycle
sel  input  SEL_W  destination bit index for din
clr  input  1  synchronous abort of the current frame
slots  output  N  live per-bit data registers
filled  output  N  mask of positions written in the current frame
dout  output  N  last completed word
dout_valid  output  1  one-cycle pulse: dout updated this cycle
dup_err  output  1  one-cycle pulse: a position was written twice in the same frame
busy  output  1  state == COLLECT

Behaviour:
- Reset (rst_n=0, asynchronous): slots=0, filled=0, dout=0, dout_valid=0, dup_err=0, state=IDLE.
- State machine: IDLE (filled==0) and COLLECT (filled!=0, not yet complete). busy=1 only in COLLECT.
- On a clock edge with din_valid=1 and clr=0:
  - slots[sel] <= din.
  - If filled[sel] was 0: set filled[sel] <= 1.
  - If filled[sel] was already 1: the data is overwritten, filled is unchanged, and dup_err=1 on the next cycle.
- Completion: when the write makes filled all-ones (filled | onehot(sel) == all-ones):
  - Same edge: dout <= the updated slots, including the incoming bit.
  - Same edge: filled <= 0 and state <= IDLE.
  - dout_valid=1 for exactly one cycle, i.e. the cycle after the completing write.
  - Latency: completing write edge to dout_valid high = 1 clock.
- The last write of a frame may come from any sel; the order of sel values is free.
- Back-to-back frames: a write on the cycle immediately after completion starts a new frame with no bubble.
- clr=1: filled <= 0 and state <= IDLE. slots and dout are retained. clr has priority over a simultaneous din_valid, so that write is dropped with no dup_err and no completion.
- din_valid=0: no register changes; dout_valid and dup_err return to 0.
- dout holds its value between completions and changes only on completion or reset.
- Reset asserted mid-frame: all state clears immediately, and no dout_valid is produced for the partial frame.
- sel is SEL_W bits wide, so every value is a legal index and there are no out-of-range cases.

Test Plan:
1. Reset then sweep: din = bits of 8'b10101010 with sel 0..7, one per cycle, din_valid=1. Required: dout=8'hAA, dout_valid high exactly one cycle after the sel=7 write, filled returns to 0, busy low afterwards.
2. Back-to-back frames: frame 8'b11110000 with sel 0..7 immediately follows frame 1. Required: second dout_valid exactly 8 cycles after the first, dout=8'hF0.
3. Reverse and random order: sel 7..0 carrying the bits of 8'h5A. Required: dout=8'h5A. Interleave din_valid=0 gaps of 0–3 cycles. Required: same result, with dout_valid only after the 8th write.
4. Duplicate write: sel 0..3 written, then sel=2 written again with the opposite bit, then sel 4..7. Required: dup_err pulses one cycle after the repeat, no dout_valid until sel=7, and dout reflects the overwritten bit 2.
5. clr mid-frame: write sel 0..4, then assert clr together with din_valid at sel=5. Required: filled=0, busy=0, no dout_valid, dout unchanged. A following full sweep of 8'hAA must give dout=8'hAA.
6. Asynchronous reset: assert rst_n low between clock edges after 5 writes. Required: all outputs 0 immediately. After release, a full sweep of 8'hF0 must give dout=8'hF0 with a single dout_valid.
